// File: rtl/rv32i_types.sv
// Shared RV32 type definitions; M-extension op encoding and operand-signedness helpers.
package rv32i_types;

    typedef enum logic [2:0] {
        M_MUL    = 3'd0,
        M_MULH   = 3'd1,
        M_MULHSU = 3'd2,
        M_MULHU  = 3'd3,
        M_DIV    = 3'd4,
        M_DIVU   = 3'd5,
        M_REM    = 3'd6,
        M_REMU   = 3'd7
    } m_funct3_t;

    function automatic logic a_is_signed(input m_funct3_t op);
        return op inside {M_MUL, M_MULH, M_MULHSU, M_DIV, M_REM};
    endfunction

    function automatic logic b_is_signed(input m_funct3_t op);
        return op inside {M_MUL, M_MULH, M_DIV, M_REM};
    endfunction

    function automatic logic is_div_op(input m_funct3_t op);
        return op inside {M_DIV, M_DIVU, M_REM, M_REMU};
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative magnitude datapath: radix-2 shift-add multiply or restoring divide,
// one bit per enabled step. The accumulator holds {hi, lo} = {partial/rem, multiplier/quotient}.
module muldiv_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 div_mode,
    input  logic [WIDTH-1:0]     init_lo,
    input  logic [WIDTH-1:0]     init_op,
    output logic [2*WIDTH-1:0]   acc_next_c
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               div_q;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;

    // Value the accumulator takes after one more iteration
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        acc_next_c = {sum, acc[WIDTH-1:1]};
        if (div_q) begin
            if (!diff[WIDTH]) begin
                acc_next_c = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next_c = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            opnd  <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            acc   <= {{WIDTH{1'b0}}, init_lo};
            opnd  <= init_op;
            div_q <= div_mode;
        end else if (step) begin
            acc   <= acc_next_c;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: control FSM, special-case shortcut and sign
// correction around the iterative muldiv_core datapath.
module muldiv_unit
    import rv32i_types::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    m_funct3_t         op, op_d, req_op;
    logic              a_neg_q, b_neg_q, a_neg_d, b_neg_d;
    logic [WIDTH-1:0]  result_d;
    logic [WIDTH-1:0]  a_mag, b_mag, special_res, fixed_res;
    logic [2*WIDTH-1:0] prod, acc_next_c;
    logic              special, load_c, step_c;
    logic [WIDTH-1:0]  init_lo_c, init_op_c;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .rst        (rst),
        .load       (load_c),
        .step       (step_c),
        .div_mode   (is_div_op(req_op)),
        .init_lo    (init_lo_c),
        .init_op    (init_op_c),
        .acc_next_c (acc_next_c)
    );

    always_comb begin
        req_op = m_funct3_t'(funct3);
        a_mag  = (a_is_signed(req_op) && a[WIDTH-1]) ? -a : a;
        b_mag  = (b_is_signed(req_op) && b[WIDTH-1]) ? -b : b;
        a_neg_d = a_is_signed(req_op) && a[WIDTH-1];
        b_neg_d = b_is_signed(req_op) && b[WIDTH-1];
        init_lo_c = is_div_op(req_op) ? a_mag : b_mag;
        init_op_c = is_div_op(req_op) ? b_mag : a_mag;

        // Divide-by-zero and signed overflow finish without iterating
        special     = 1'b0;
        special_res = '0;
        if (is_div_op(req_op)) begin
            if (b == '0) begin
                special     = 1'b1;
                special_res = (req_op inside {M_DIV, M_DIVU}) ? '1 : a;
            end else if (b_is_signed(req_op) && a == MOST_NEG && b == '1) begin
                special     = 1'b1;
                special_res = (req_op == M_DIV) ? a : '0;
            end
        end

        // Sign-corrected result from the final iteration's accumulator
        prod      = (a_neg_q ^ b_neg_q) ? -acc_next_c : acc_next_c;
        fixed_res = (op == M_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        if (op inside {M_DIV, M_DIVU}) begin
            fixed_res = (a_neg_q ^ b_neg_q) ? -acc_next_c[WIDTH-1:0] : acc_next_c[WIDTH-1:0];
        end else if (op inside {M_REM, M_REMU}) begin
            fixed_res = a_neg_q ? -acc_next_c[2*WIDTH-1:WIDTH] : acc_next_c[2*WIDTH-1:WIDTH];
        end

        state_d  = state;
        cnt_d    = cnt;
        op_d     = op;
        result_d = result;
        load_c   = 1'b0;
        step_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d   = req_op;
                    cnt_d  = '0;
                    load_c = 1'b1;
                    if (special) begin
                        state_d  = S_DONE;
                        result_d = special_res;
                    end else begin
                        state_d  = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    step_c = 1'b1;
                    cnt_d  = cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state_d  = S_DONE;
                        result_d = fixed_res;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op      <= M_MUL;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            op      <= op_d;
            result  <= result_d;
            busy    <= (state_d != S_IDLE);
            done    <= (state_d == S_DONE);
            if (load_c) begin
                a_neg_q <= a_neg_d;
                b_neg_q <= b_neg_d;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, flush/reset cases, random ops.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          t0;
        int          lat;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] last_res;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference RV32M semantics from wide arithmetic
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, uy;
        logic [63:0] p;
        logic        ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        uy  = longint'({32'h0, y});
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = 64'(sx * sy); return p[31:0]; end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * uy); return p[63:32]; end
            3'd3: begin p = {32'h0, x} * {32'h0, y}; return p[63:32]; end
            3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 0 || ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(result), 64'hDEAD_0000_0000);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_res"}, 64'(result), 64'(e.res));
                check({e.tag, "_lat"}, 64'(cyc - e.t0 + 1), 64'(e.lat));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the done cycle
    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] res, input int lat, input string tag, input logic poke);
        int n;
        int bad;
        exp_t ex;
        funct3 = f; a = x; b = y; start = 1'b1;
        ex.res = res; ex.t0 = cyc + 1; ex.lat = lat; ex.tag = tag;
        sb.push_back(ex);
        last_res = res;
        @(negedge clk);
        start = 1'b0;
        n = 1; bad = 0;
        while (!done && n < 100) begin
            if (!busy) bad++;
            if (poke && n == 5) begin
                start = 1'b1; funct3 = 3'd0; a = 32'h1234; b = 32'h5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!done) check({tag, "_timeout"}, 64'(n), 64'(lat));
        if (!busy) bad++;
        check({tag, "_busy"}, 64'(bad), 64'h0);
        @(negedge clk);
        check({tag, "_pulse"}, {62'h0, done, busy}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] pool [6];
        logic [31:0] x, y;
        logic [2:0]  f;
        int          t0;

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; a = '0; b = '0;
        last_res = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_state", {30'h0, busy, done, result}, 64'h0);

        issue(3'd0, 32'd7, 32'd6, 32'h0000_002A, 33, "mul_7x6", 1'b0);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh_m1", 1'b0);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_m1", 1'b0);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_m1", 1'b0);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7", 1'b1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7", 1'b0);
        issue(3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, "divu_z", 1'b0);
        issue(3'd7, 32'd100, 32'd0, 32'd100, 1, "remu_z", 1'b0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf", 1'b0);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf", 1'b0);

        // start together with flush in IDLE is ignored
        funct3 = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("start_flush_idle", {62'h0, busy, done}, 64'h0);

        // flush mid-multiply at T+10, restart at T+11
        funct3 = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {30'h0, busy, done, result}, {32'h0, last_res});
        issue(3'd0, 32'd12345, 32'd678, 32'd8369910, 33, "mul_after_flush", 1'b0);

        // reset mid-divide at T+5, restart at T+6
        funct3 = 3'd5; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_op", {30'h0, busy, done, result}, 64'h0);
        issue(3'd5, 32'd1000, 32'd7, 32'd142, 33, "divu_after_rst", 1'b0);

        pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'h0;
        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom_range(0, 7));
            x = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            issue(f, x, y, model(f, x, y), model_lat(f, x, y), $sformatf("rnd%0d_f%0d", i, f), 1'b0);
        end

        t0 = 0;
        while (sb.size() != 0 && t0 < 50) begin
            @(negedge clk);
            t0++;
        end
        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
